// File: rtl/median_window_sched_pkg.sv
// Shared definitions for the 3x3 median window sequencer: default geometry, BRAM layout,
// FSM state encoding and the border test used to force edge pixels to zero.
package median_window_sched_pkg;

    localparam int unsigned DefBitWidth  = 8;
    localparam int unsigned DefAddrWidth = 14;
    localparam int unsigned DefImgW      = 100;
    localparam int unsigned DefImgH      = 100;
    localparam int unsigned DefHdrOffset = 1078;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StDrain,
        StDone
    } state_e;

    // True when (row, col) lies on any of the four image borders.
    function automatic logic is_border(input logic [31:0] row, input logic [31:0] col,
                                       input logic [31:0] img_h, input logic [31:0] img_w);
        return (row == 32'd0) || (row == img_h - 32'd1) ||
               (col == 32'd0) || (col == img_w - 32'd1);
    endfunction

endpackage

// File: rtl/median_window_sched_line_buf.sv
// Line buffer: DEPTH-deep shift register of WIDTH-bit pixels, advancing only when en is high.
//  clk   in   clock
//  en    in   shift enable
//  din   in   pixel entering the buffer
//  dout  out  pixel that entered DEPTH enabled shifts ago
// Contents are not reset; stale data only ever reaches border windows, which are forced to 0.
module median_window_sched_line_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 100
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/median_window_sched.sv
// Sequencer for the 3x3 median datapath. Streams the image once in raster order from a single
// BRAM read port, builds the 3x3 window from two line buffers, presents it to the external
// combinational median kernel and emits one filtered pixel per accepted cycle.
//  clk          in   clock
//  rst          in   synchronous active-high reset
//  header_done  in   header stage finished; start ignored while low
//  domedian     in   start pulse, sampled in idle only
//  bram_addr    out  BRAM read address (HDR_OFFSET + pixel index)
//  bram_dout    in   BRAM read data, valid one cycle after the address
//  win_data     out  window {p8..p0}, p0 top-left, p4 centre, p8 bottom-right
//  median_in    in   median of win_data
//  pix_out      out  filtered pixel, raster order
//  pix_valid    out  pix_out valid
//  pix_ready    in   sink accepts pix_out
//  busy         out  frame in progress
//  median_done  out  one-cycle pulse after the last pixel is accepted
module median_window_sched
    import median_window_sched_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = DefBitWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned IMG_W      = DefImgW,
    parameter int unsigned IMG_H      = DefImgH,
    parameter int unsigned HDR_OFFSET = DefHdrOffset
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   header_done,
    input  logic                   domedian,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    input  logic [BIT_WIDTH-1:0]   bram_dout,
    output logic [9*BIT_WIDTH-1:0] win_data,
    input  logic [BIT_WIDTH-1:0]   median_in,
    output logic [BIT_WIDTH-1:0]   pix_out,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   busy,
    output logic                   median_done
);

    localparam int unsigned NumPix = IMG_W * IMG_H;
    localparam logic [ADDR_WIDTH-1:0] AddrBase = ADDR_WIDTH'(HDR_OFFSET);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;     // reads issued
    logic [31:0]           out_cnt_q, out_cnt_d;   // outputs registered
    logic [31:0]           fill_cnt_q, fill_cnt_d; // pixels shifted during fill
    logic [31:0]           row_q, row_d, col_q, col_d;
    logic                  rd_pend_q, rd_pend_d;   // bram_dout holds an unconsumed read
    logic                  skid_v_q, skid_v_d;
    logic [BIT_WIDTH-1:0]  skid_q, skid_d;
    logic [BIT_WIDTH-1:0]  pix_q, pix_d;
    logic                  valid_q, valid_d;
    logic [BIT_WIDTH-1:0]  win_q [9];
    logic [BIT_WIDTH-1:0]  lb1_out, lb2_out, in_data;
    logic                  active, adv, reads_left, outs_left, in_avail, step, issue, emit;

    median_window_sched_line_buf #(.WIDTH(BIT_WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .en   (step),
        .din  (in_data),
        .dout (lb1_out)
    );

    median_window_sched_line_buf #(.WIDTH(BIT_WIDTH), .DEPTH(IMG_W)) u_lb2 (
        .clk  (clk),
        .en   (step),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Pixel source: the skid entry drains first, then live BRAM data, then zeros once all
    // reads are consumed (flushes the last window rows out).
    always_comb begin
        active     = (state_q == StFill) || (state_q == StRun) || (state_q == StDrain);
        adv        = !valid_q || pix_ready;
        reads_left = (rd_cnt_q != NumPix);
        outs_left  = (out_cnt_q != NumPix);
        in_avail   = 1'b1;
        in_data    = '0;
        if (skid_v_q) begin
            in_data = skid_q;
        end else if (rd_pend_q) begin
            in_data = bram_dout;
        end else begin
            in_avail = !reads_left;
        end
        step  = active && adv && in_avail && outs_left;
        issue = active && adv && reads_left;
        emit  = step && (state_q != StFill);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        fill_cnt_d = fill_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_pend_d  = rd_pend_q;
        skid_v_d   = skid_v_q;
        skid_d     = skid_q;
        pix_d      = pix_q;
        valid_d    = valid_q;

        case (state_q)
            StIdle: begin
                if (domedian && header_done) begin
                    state_d    = StFill;
                    addr_d     = AddrBase;
                    rd_cnt_d   = '0;
                    out_cnt_d  = '0;
                    fill_cnt_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                    rd_pend_d  = 1'b0;
                    skid_v_d   = 1'b0;
                end
            end
            // Window for centre 0 is complete once pixel IMG_W+1 has been shifted in.
            StFill:  if (step && (fill_cnt_q == IMG_W + 1)) state_d = StRun;
            StRun:   if (!reads_left) state_d = StDrain;
            StDrain: if (!outs_left && adv) state_d = StDone;
            StDone: begin
                state_d = StIdle;
                addr_d  = AddrBase;
            end
            default: state_d = StIdle;
        endcase

        if (active) begin
            rd_pend_d = issue;
            if (issue) begin
                rd_cnt_d = rd_cnt_q + 32'd1;
                // Hold on the last pixel address rather than stepping past the image.
                if (rd_cnt_q + 32'd1 < NumPix) addr_d = addr_q + ADDR_WIDTH'(1);
            end
            // A stall catches the in-flight read; it is consumed first on resume.
            if (rd_pend_q && !adv) begin
                skid_v_d = 1'b1;
                skid_d   = bram_dout;
            end else if (step) begin
                skid_v_d = 1'b0;
            end
            if (step && (state_q == StFill)) fill_cnt_d = fill_cnt_q + 32'd1;
            if (adv) valid_d = emit;
            if (emit) begin
                pix_d     = is_border(row_q, col_q, IMG_H, IMG_W) ? '0 : median_in;
                out_cnt_d = out_cnt_q + 32'd1;
                if (col_q == IMG_W - 1) begin
                    col_d = '0;
                    row_d = row_q + 32'd1;
                end else begin
                    col_d = col_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= AddrBase;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            fill_cnt_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rd_pend_q  <= 1'b0;
            skid_v_q   <= 1'b0;
            skid_q     <= '0;
            pix_q      <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_pend_q  <= rd_pend_d;
            skid_v_q   <= skid_v_d;
            skid_q     <= skid_d;
            pix_q      <= pix_d;
            valid_q    <= valid_d;
            if (step) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb2_out;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_out;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= in_data;
            end
        end
    end

    assign win_data    = {win_q[8], win_q[7], win_q[6], win_q[5], win_q[4],
                          win_q[3], win_q[2], win_q[1], win_q[0]};
    assign bram_addr   = addr_q;
    assign pix_out     = pix_q;
    assign pix_valid   = valid_q;
    assign busy        = active;
    assign median_done = (state_q == StDone);

endmodule

// File: tb/tb_median_window_sched.sv
module tb_median_window_sched;

    localparam int W   = 100;
    localparam int H   = 100;
    localparam int N   = W * H;
    localparam int HDR = 1078;
    localparam int SN  = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, header_done, domedian, pix_ready;
    logic [13:0] bram_addr;
    logic [7:0]  bram_dout, median_in, pix_out;
    logic [71:0] win_data;
    logic        pix_valid, busy, median_done;

    logic        domedian_s, pix_ready_s;
    logic [13:0] bram_addr_s;
    logic [7:0]  bram_dout_s, median_in_s, pix_out_s;
    logic [71:0] win_data_s;
    logic        pix_valid_s, busy_s, median_done_s;

    median_window_sched #(.BIT_WIDTH(8), .ADDR_WIDTH(14), .IMG_W(W), .IMG_H(H),
                          .HDR_OFFSET(HDR)) dut (
        .clk(clk), .rst(rst), .header_done(header_done), .domedian(domedian),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .win_data(win_data),
        .median_in(median_in), .pix_out(pix_out), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .median_done(median_done)
    );

    median_window_sched #(.BIT_WIDTH(8), .ADDR_WIDTH(14), .IMG_W(4), .IMG_H(3),
                          .HDR_OFFSET(HDR)) dut_s (
        .clk(clk), .rst(rst), .header_done(header_done), .domedian(domedian_s),
        .bram_addr(bram_addr_s), .bram_dout(bram_dout_s), .win_data(win_data_s),
        .median_in(median_in_s), .pix_out(pix_out_s), .pix_valid(pix_valid_s),
        .pix_ready(pix_ready_s), .busy(busy_s), .median_done(median_done_s)
    );

    // Median kernel: sort nine values, take the middle one.
    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        return a[4];
    endfunction

    assign median_in   = median9(win_data);
    assign median_in_s = median9(win_data_s);

    logic [7:0] img   [N];
    logic [7:0] img_s [SN];

    function automatic logic [7:0] rd_img(input logic [13:0] addr);
        int a = int'(addr) - HDR;
        return (a >= 0 && a < N) ? img[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_img_s(input logic [13:0] addr);
        int a = int'(addr) - HDR;
        return (a >= 0 && a < SN) ? img_s[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        bram_dout   <= rd_img(bram_addr);
        bram_dout_s <= rd_img_s(bram_addr_s);
    end

    // Reference output for centre c, straight from the source image.
    function automatic logic [7:0] gold(input int c);
        int r = c / W;
        int k = c % W;
        logic [71:0] w;
        if (r == 0 || r == H - 1 || k == 0 || k == W - 1) return 8'h00;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[(dr*3+dc)*8 +: 8] = img[(r - 1 + dr) * W + (k - 1 + dc)];
        return median9(w);
    endfunction

    task automatic load_img(input int kind);
        for (int i = 0; i < N; i++) img[i] = (kind == 0) ? 8'(i % 256) : 8'd10;
        if (kind == 1) img[50 * W + 50] = 8'd255;
    endtask

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    logic [7:0] outs [$];
    int first_valid, done_cnt, stall_bad, timeout;

    // Runs one frame on the large instance. ready_mode 1 = alternate ready with random 5-cycle
    // stalls. pulse_cyc >= 0 pulses domedian at that cycle. abort_at >= 0 resets after that
    // many accepted outputs.
    task automatic run_frame(input int ready_mode, input int pulse_cyc, input int abort_at);
        int cyc, stall_left, post;
        logic [7:0] held;
        bit was_stall, hs;
        outs.delete();
        first_valid = -1; done_cnt = 0; stall_bad = 0; timeout = 0;
        stall_left = 0; post = 0;
        @(posedge clk); #1;
        domedian = 1'b1; pix_ready = 1'b1;
        @(posedge clk); #1;
        domedian = 1'b0;
        cyc = 0;
        while (1) begin
            if (ready_mode == 1) begin
                if (stall_left == 0 && $urandom_range(0, 31) == 0) stall_left = 5;
                pix_ready = (stall_left == 0) && (cyc % 2 == 0);
                if (stall_left > 0) stall_left--;
            end else begin
                pix_ready = 1'b1;
            end
            domedian  = (cyc + 1 == pulse_cyc);
            hs        = pix_valid && pix_ready;
            was_stall = pix_valid && !pix_ready;
            held      = pix_out;
            if (hs) outs.push_back(pix_out);
            @(posedge clk); #1;
            cyc++;
            domedian = 1'b0;
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (was_stall && (!pix_valid || pix_out != held)) stall_bad++;
            if (median_done) done_cnt++;
            if (abort_at >= 0 && outs.size() >= abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (done_cnt > 0) begin
                post++;
                if (post == 4) break;
            end
            if (cyc > 60000) begin
                timeout = 1;
                break;
            end
        end
        pix_ready = 1'b1;
    endtask

    typedef struct {
        string name;
        int    img_kind;
        int    ready_mode;
        int    pulse_cyc;
        int    exp_count;
        int    exp_first;
        int    probe_idx;
        int    probe_val;
    } vec_t;

    vec_t vecs [3];
    logic [7:0] outs_s [$];
    logic [7:0] exp_s [SN];

    initial begin
        int bad, cyc, first_s, done_s, mism;

        vecs[0] = '{"ramp_pulse", 0, 0, 200, N, W + 4, 101, 101};
        vecs[1] = '{"salt",       1, 0, -1,  N, W + 4, 50 * W + 50, 10};
        vecs[2] = '{"ramp_bp",    0, 1, -1,  N, W + 4, 101, 101};
        exp_s   = '{0, 0, 0, 0, 0, 6, 7, 0, 0, 0, 0, 0};

        rst = 1'b1; header_done = 1'b1; domedian = 1'b0; pix_ready = 1'b1;
        domedian_s = 1'b0; pix_ready_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset bram_addr", int'(bram_addr), HDR);
        check("reset pix_valid", int'(pix_valid), 0);
        check("reset pix_out", int'(pix_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset median_done", int'(median_done), 0);
        check("reset win_data", int'(win_data == 72'd0), 1);
        rst = 1'b0;

        // Start with header_done low is ignored.
        header_done = 1'b0;
        @(posedge clk); #1;
        domedian = 1'b1;
        @(posedge clk); #1;
        domedian = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || pix_valid) bad++;
            @(posedge clk); #1;
        end
        check("no_header idle", bad, 0);
        check("no_header bram_addr", int'(bram_addr), HDR);
        header_done = 1'b1;

        // 4x3 image, pixel i = i+1.
        for (int i = 0; i < SN; i++) img_s[i] = 8'(i + 1);
        outs_s.delete();
        @(posedge clk); #1;
        domedian_s = 1'b1;
        @(posedge clk); #1;
        domedian_s = 1'b0;
        cyc = 0; first_s = -1; done_s = 0;
        for (int i = 0; i < 60; i++) begin
            if (pix_valid_s) outs_s.push_back(pix_out_s);
            @(posedge clk); #1;
            cyc++;
            if (pix_valid_s && first_s < 0) first_s = cyc;
            if (median_done_s) done_s++;
        end
        check("small count", outs_s.size(), SN);
        check("small first_valid", first_s, 8);
        check("small done", done_s, 1);
        for (int i = 0; i < SN; i++)
            check($sformatf("small pix%0d", i), (i < outs_s.size()) ? int'(outs_s[i]) : -1,
                  int'(exp_s[i]));

        // Reset mid-frame after 5000 accepted outputs.
        load_img(0);
        run_frame(0, -1, 5000);
        check("abort reached", outs.size(), 5000);
        check("abort pix_valid", int'(pix_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort bram_addr", int'(bram_addr), HDR);

        // Full frames; the first doubles as the restart after the reset.
        for (int v = 0; v < 3; v++) begin
            load_img(vecs[v].img_kind);
            run_frame(vecs[v].ready_mode, vecs[v].pulse_cyc, -1);
            mism = 0;
            for (int c = 0; c < N && c < outs.size(); c++)
                if (outs[c] != gold(c)) mism++;
            check({vecs[v].name, " timeout"}, timeout, 0);
            check({vecs[v].name, " count"}, outs.size(), vecs[v].exp_count);
            check({vecs[v].name, " first_valid"}, first_valid, vecs[v].exp_first);
            check({vecs[v].name, " stream mismatches"}, mism, 0);
            check({vecs[v].name, " probe"},
                  (vecs[v].probe_idx < outs.size()) ? int'(outs[vecs[v].probe_idx]) : -1,
                  vecs[v].probe_val);
            check({vecs[v].name, " last pixel"},
                  (outs.size() == N) ? int'(outs[N-1]) : -1, 0);
            check({vecs[v].name, " done pulses"}, done_cnt, 1);
            check({vecs[v].name, " stall stability"}, stall_bad, 0);
            check({vecs[v].name, " busy after"}, int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
